// File: rtl/ctrl_byte_rx.sv
// ctrl_byte_rx
//   Receives command/data bytes from the host MCU over a mode-0 SPI slave link
//   and queues them in a show-ahead byte FIFO. The control unit reads out_byte
//   while out_ready is high and then pulses next to pop it. A status byte
//   {overflow, free slots (capped at 127)} is shifted back to the host on MISO.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   spi_sck/cs_n/mosi SPI slave inputs, asynchronous to clk (sck <= clk/8)
//   spi_miso          status byte, MSB first; 0 while not selected
//   out_byte          FIFO head byte, valid while out_ready = 1
//   out_ready         FIFO not empty
//   next              one-cycle pop strobe
//   fill_level        current entry count
//   overflow          sticky: a byte was dropped on a full FIFO
//   clear_overflow    clears overflow (an overflow in the same cycle wins)
//   frame_error       one-cycle pulse: CS released mid-byte
module ctrl_byte_rx #(
    parameter int fifo_depth  = 64,
    parameter int sync_stages = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [7:0]                    out_byte,
    output logic                          out_ready,
    input  logic                          next,
    output logic [$clog2(fifo_depth):0]   fill_level,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          frame_error
);

    localparam int            AW      = $clog2(fifo_depth);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(fifo_depth);

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [sync_stages-1:0] r_sck_sync;
    logic [sync_stages-1:0] r_cs_sync;
    logic [sync_stages-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic w_sck;
    logic w_cs_n;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[sync_stages-2:0],  spi_sck};
            r_cs_sync   <= {r_cs_sync[sync_stages-2:0],   spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[sync_stages-2:0], spi_mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
        end
    end

    assign w_sck      = r_sck_sync[sync_stages-1];
    assign w_cs_n     = r_cs_sync[sync_stages-1];
    assign w_mosi     = r_mosi_sync[sync_stages-1];
    assign w_sck_rise =  w_sck  & ~r_sck_d;
    assign w_sck_fall = ~w_sck  &  r_sck_d;
    assign w_cs_fall  = ~w_cs_n &  r_cs_d;
    assign w_cs_rise  =  w_cs_n & ~r_cs_d;

    // ------------------------------------------------------------------
    // RX framing
    // ------------------------------------------------------------------
    // The synchronised cs_n is 0 straight after reset, so a frame that was
    // already running when reset hit would otherwise be picked up mid-byte.
    // r_armed only becomes true on a genuine CS falling edge.
    logic       r_armed;
    logic [2:0] r_bit_ctr;
    logic [6:0] r_rx_shift;
    logic       r_frame_error;
    logic [7:0] r_tx_shift;

    logic       w_rx_active;
    logic       w_push;
    logic [7:0] w_push_byte;

    assign w_rx_active = r_armed & ~w_cs_n;
    assign w_push      = w_rx_active & w_sck_rise & (r_bit_ctr == 3'd7);
    assign w_push_byte = {r_rx_shift, w_mosi};

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [fifo_depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [AW:0]   w_free;
    logic [6:0]    w_free7;

    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = next & (r_count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // alongside a pop is still accepted.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_free  = C_DEPTH - r_count;
    assign w_free7 = (32'(w_free) > 32'd127) ? 7'h7f : 7'(w_free);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed       <= 1'b0;
            r_bit_ctr     <= 3'd0;
            r_rx_shift    <= 7'd0;
            r_frame_error <= 1'b0;
            r_tx_shift    <= 8'd0;
        end else begin
            if (w_cs_rise) begin
                r_armed <= 1'b0;
            end else if (w_cs_fall) begin
                r_armed <= 1'b1;
            end

            r_frame_error <= w_cs_rise & r_armed & (r_bit_ctr != 3'd0);

            // bit_ctr wraps 7 -> 0 on its own when a byte completes
            if (!w_rx_active) begin
                r_bit_ctr <= 3'd0;
            end else if (w_sck_rise) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                r_bit_ctr  <= r_bit_ctr + 3'd1;
            end

            // Status reload at frame start and after every completed byte
            if (w_cs_fall || w_push) begin
                r_tx_shift <= {r_overflow, w_free7};
            end else if (w_rx_active && w_sck_fall) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    // Byte storage: no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // set has priority over clear
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Show-ahead head read is asynchronous so a pushed byte is visible the
    // cycle after its push; masked to 0 while empty so the output never
    // exposes uninitialised storage.
    assign out_byte    = (r_count != '0) ? r_mem[r_rd_ptr] : 8'd0;
    assign out_ready   = (r_count != '0);
    assign fill_level  = r_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;
    assign spi_miso    = w_rx_active & r_tx_shift[7];

endmodule

// File: doc/ctrl_byte_rx.md
Name: ctrl_byte_rx

Overview:
- Upstream neighbour of the sequenced control unit. Receives command/data bytes from the host MCU over a mode-0 SPI slave link and buffers them in a show-ahead byte FIFO.
- Presents bytes on the out_byte/out_ready/next handshake that the control unit consumes: the control unit samples out_byte while out_ready is high, then pulses next to pop.
- Returns a status byte on MISO so the host can throttle itself.

Parameters:
- fifo_depth, 64, byte FIFO entries; power of two, minimum 4.
- sync_stages, 2, synchroniser flops on spi_sck, spi_cs_n and spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- spi_sck  in  1  SPI clock, asynchronous to clk; frequency at most clk/8
- spi_cs_n  in  1  SPI chip select, active low, asynchronous
- spi_mosi  in  1  SPI data in, asynchronous
- spi_miso  out  1  SPI status data out
- out_byte  out  8  FIFO head byte, valid while out_ready=1
- out_ready  out  1  FIFO non-empty
- next  in  1  single-cycle pop strobe from the control unit
- fill_level  out  $clog2(fifo_depth)+1  current entry count
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full
- clear_overflow  in  1  clears overflow
- frame_error  out  1  one-cycle pulse: CS deasserted mid-byte

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clk.
- Reset values: all outputs 0. Pointers, count, bit counter, shift registers and synchroniser stages are also cleared.
- Synchronisation: sck, cs_n and mosi each pass through sync_stages flops.
  - A one-flop history of synchronised sck gives the rising edge (sck_rise) and falling edge (sck_fall).
  - A one-flop history of synchronised cs_n gives cs_fall and cs_rise.
  - All logic uses only the synchronised signals.
- RX framing: active while synchronised cs_n = 0.
  - On sck_rise, mosi shifts in MSB-first and bit_ctr (3 bits) increments.
  - When bit_ctr = 7 at an sck_rise, the completed byte {shift[6:0], mosi} raises a push request in that same cycle, and bit_ctr wraps to 0.
  - While cs_n = 1, bit_ctr is held at 0 and sck edges are ignored.
  - cs_rise with bit_ctr != 0 pulses frame_error for 1 cycle; the partial byte is discarded; bit_ctr returns to 0.
- FIFO:
  - Write on push if count < fifo_depth.
  - If full, the byte is dropped and overflow is set; the FIFO contents are unchanged.
  - out_byte = mem[rd_ptr] (show-ahead); out_ready = (count != 0).
  - Pop on next when count != 0. next while empty is ignored, with no underflow and no pointer change.
  - Pointers are $clog2(fifo_depth) bits and wrap naturally. count is kept separately; fill_level = count.
  - Simultaneous push and pop: both pointers advance, count unchanged. This holds when full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Simultaneous push and pop when count = 0: the pop is ignored and the push is accepted.
- Latency:
  - Push request in cycle t: out_ready/out_byte/fill_level reflect the new byte from cycle t+1.
  - next in cycle t: the new head is visible from cycle t+1.
  - This matches the control unit's one-cycle blanking after each next.
- Overflow flag:
  - Sticky; cleared by clear_overflow.
  - If clear_overflow and an overflowing push occur in the same cycle, the set wins.
- TX status path:
  - On cs_fall, and again each time an RX byte completes while CS is still low, load tx_shift = {overflow, free7}.
  - free7 = min(fifo_depth - count, 127), sampled in that cycle.
  - spi_miso = tx_shift[7]. On sck_fall, tx_shift shifts left, filling with 0.
  - While cs_n = 1, spi_miso = 0.
- Reset mid-frame: state clears immediately and any partial byte is lost. Reception resumes at the next cs_fall; a frame already in progress is not recovered.

Test Plan:
1. Reset, then one CS frame of 0x5A at clk/8 -> out_ready rises 1 cycle after the 8th synchronised sck_rise; out_byte=0x5A; fill_level=1. Pulse next -> out_ready=0 the following cycle.
2. Burst 0x01,0x02,0x03 in one frame, then next pulses spaced 2 cycles apart -> bytes emerge in order 01,02,03; fill_level steps 3->2->1->0; extra next while empty leaves fill_level=0.
3. fifo_depth=4: send 5 bytes with no pops -> fill_level=4, overflow=1, head still first byte. Pulse clear_overflow -> overflow=0.
4. FIFO full, with push and next in the same cycle -> fill_level stays 4, overflow stays 0, and the new byte is last out after 4 pops.
5. Raise CS after 5 bits -> frame_error pulses exactly 1 cycle; FIFO unchanged. The next full frame 0xA5 is received correctly.
6. With 3 bytes queued in a depth-64 FIFO, host clocks a frame -> MISO shifts 0x3D (overflow=0, free=61) MSB-first, changing after each sck falling edge; spi_miso=0 while CS is high.
